// File: rtl/word_fifo_pkg.sv
// Shared definitions for the word FIFO: default geometry and pointer sizing.
package word_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 3;
  localparam int FIFO_DEPTH_DEF = 4;

  // Pointer width for a power-of-two depth; the count needs one bit more.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/word_fifo_mem.sv
// DEPTH x WIDTH storage for the word FIFO with a synchronous write port and a
// registered read port. Only the read register is reset; the array is not.
module word_fifo_mem
  import word_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        re,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address when a write is accepted.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Capture the addressed word on an accepted read; hold it otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/word_fifo.sv
// Word FIFO buffering the parallel register output for a slower consumer.
// Circular buffer with read/write pointers and an occupancy counter; full and
// empty are decoded from the counter.
// Optional build macro WORD_FIFO_ERR_FLAGS_EN adds sticky ovf/udf outputs.
module word_fifo
  import word_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
`ifdef WORD_FIFO_ERR_FLAGS_EN
  output logic                      ovf,
  output logic                      udf,
`endif
  output logic [ptr_width(DEPTH):0] count
);

  localparam int ADDR_W = ptr_width(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // full/empty come straight from the counter, so a full FIFO rejects writes
  // and an empty one rejects reads (no write-to-read pass-through).
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  word_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (rd_acc),
    .raddr(rd_ptr),
    .rdata(dout)
  );

  // Advance pointers on accepted transfers; they wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // rd_valid marks the cycle where dout carries a freshly popped word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

`ifdef WORD_FIFO_ERR_FLAGS_EN
  // Sticky error flags: record any rejected write or read until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full) begin
        ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/word_fifo.md
Name: word_fifo

Overview:
- Synchronous FIFO that sits directly downstream of the 3-bit parallel register and buffers its q output words.
- Decouples the register's one-word-per-clock output from a consumer that reads at its own pace.
- Storage is a circular buffer with read/write pointers and an occupancy counter.
- Single clock domain.

Parameters:
- WIDTH, 3: data word width in bits; matches the register output.
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH): pointer width; local, derived, not overridable.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-low reset (asserts on 0, releases on 1).
- din  input  WIDTH  write data, normally the register q.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- dout  output  WIDTH  read data, registered.
- rd_valid  output  1  dout holds a newly popped word this cycle.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, rd_valid=0, empty=1, full=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored words immediately. The first edge after release behaves as an empty FIFO.
- Write accept: wr_en && !full, with full sampled at the start of the cycle.
  - On accept: mem[wr_ptr] <= din and wr_ptr increments modulo DEPTH.
- Read accept: rd_en && !empty, with empty sampled at the start of the cycle.
  - On accept: dout <= mem[rd_ptr], rd_ptr increments modulo DEPTH, rd_valid <= 1.
- rd_valid: 0 on any cycle with no read accept. dout holds its last value.
- Read latency: 1 clock from the accepted rd_en edge to dout/rd_valid.
- Write-to-read: a word written at edge N is readable at the earliest with rd_en sampled at edge N+1, and appears on dout after edge N+1.
- count update:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged on both accepts or neither.
- full/empty are combinational decodes of count; there is no separate state.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: write accepted, read rejected (no pass-through), rd_valid=0.
  - Full: read accepted, write rejected; the din word is dropped.
- Overflow (wr_en while full, no read): write ignored, all state unchanged.
- Underflow (rd_en while empty): ignored, dout unchanged, rd_valid=0.
- Pointer wrap: ADDR_W-bit pointers wrap naturally from DEPTH-1 to 0. Ordering is strict FIFO across the wrap.
- There is no state machine beyond pointers and count. Legal states are count 0..DEPTH; count > DEPTH is unreachable.

Optional Feature:
- Macro: WORD_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs ovf (1 bit) and udf (1 bit), both sticky.
  - ovf sets on a rejected write (wr_en && full && write rejected).
  - udf sets on rd_en && empty.
  - Both clear only on reset (to 0).
- Not defined: ports absent, rejected requests silently ignored. The core behaviour is identical in both builds.

Decomposition:
- Package word_fifo_pkg holds:
  - FIFO_WIDTH_DEF=3
  - FIFO_DEPTH_DEF=4
  - a localparam function for the pointer width.
- One natural sub-module: word_fifo_mem.
  - DEPTH x WIDTH storage.
  - Synchronous write port and registered read port: we, waddr, wdata, re, raddr, rdata.
- Pointers, count and flags stay in word_fifo.

Test Plan (WIDTH=3, DEPTH=4):
- Reset: hold rst=0 for 12 units, release -> empty=1, full=0, count=0, dout=0, rd_valid=0. Assert rst=0 asynchronously mid-clock with count=2 -> count=0 and empty=1 immediately, without waiting for an edge.
- Fill: write 3'b101, 3'b110, 3'b001, 3'b011 on consecutive edges -> count=4, full=1. Fifth write 3'b111 -> ignored, count stays 4 (ovf=1 if the feature is enabled).
- Drain: rd_en on 4 edges -> dout sequence 101, 110, 001, 011 with rd_valid=1 each, one cycle after each read. Fifth read -> rd_valid=0, dout stays 011, empty=1 (udf=1 if enabled).
- Wrap: write 2, read 2, then write 4 -> the pointers wrap, and reading back returns the last 4 words in order.
- Simultaneous at count=2: wr_en=rd_en=1 -> count stays 2 and dout is the oldest word. At count=0, both asserted with din=3'b100 -> count=1, rd_valid=0, and the next read returns 100. At count=4, both asserted -> count=3 and din is dropped.
